// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result path: field layout of data_out/status_out
// and the packed record that the result FIFO stores.
package fpu_pkg;

    localparam int DATA_W = 32;
    localparam int STAT_W = 4;
    localparam int EXP_W  = 6;
    localparam int FRAC_W = 25;
    localparam int BIAS   = 31;

    localparam int ST_EXACT = 0;
    localparam int ST_OVF   = 1;
    localparam int ST_UNF   = 2;
    localparam int ST_INX   = 3;

    // Field order matches {data_out, status_out}, so the raw concatenation casts directly.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic [STAT_W-1:0] status;
    } fpu_res_t;

endpackage

// File: rtl/fpu_res_fifo.sv
// Generic synchronous FIFO; an extra pointer bit separates full from empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fpu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fpu_result_reader.sv
// Detects newly completed FPU results, queues them, and presents the FIFO head
// decoded as sign / unbiased exponent / mantissa with hidden bit.
module fpu_result_reader
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clock100KHz,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      fpu_data_in,
    input  logic [STAT_W-1:0]      fpu_status_in,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_sign,
    output logic [EXP_W:0]         res_exp,
    output logic [FRAC_W:0]        res_mant,
    output logic [STAT_W-1:0]      res_flags,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       ovf_cnt,
    output logic [CNT_W-1:0]       unf_cnt,
    output logic [CNT_W-1:0]       inx_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    logic [DATA_W-1:0] smp_data;
    logic [STAT_W-1:0] smp_stat;
    logic [DATA_W-1:0] prv_data;
    logic [STAT_W-1:0] prv_stat;

    logic     capture;
    logic     pop;
    logic     fifo_full;
    logic     fifo_empty;
    fpu_res_t head;

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            smp_data <= '0;
            smp_stat <= '0;
            prv_data <= '0;
            prv_stat <= '0;
        end else begin
            smp_data <= fpu_data_in;
            smp_stat <= fpu_status_in;
            prv_data <= smp_data;
            prv_stat <= smp_stat;
        end
    end

    // A held result is taken once; a changed result is taken again even without a 0000 gap.
    assign capture = (smp_stat != '0) &&
                     ((prv_stat == '0) || ({smp_data, smp_stat} != {prv_data, prv_stat}));
    assign pop     = res_valid && res_ready;

    fpu_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fpu_res_t))
    ) u_fifo (
        .clk     (clock100KHz),
        .rst_n   (reset),
        .push    (capture),
        .pop     (pop),
        .wr_data (fpu_res_t'({smp_data, smp_stat})),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Flag counters count every capture, including those the FIFO had to drop.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            ovf_cnt  <= '0;
            unf_cnt  <= '0;
            inx_cnt  <= '0;
            drop_cnt <= '0;
        end else if (capture) begin
            if (smp_stat[ST_OVF] && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + CNT_W'(1);
            if (smp_stat[ST_UNF] && (unf_cnt != '1)) unf_cnt <= unf_cnt + CNT_W'(1);
            if (smp_stat[ST_INX] && (inx_cnt != '1)) inx_cnt <= inx_cnt + CNT_W'(1);
            if (fifo_full && !pop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign res_valid = !fifo_empty;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // value held and no latch is inferred.
    always_comb begin
        res_sign  = 1'b0;
        res_exp   = '0;
        res_mant  = '0;
        res_flags = '0;
        if (res_valid) begin
            res_sign  = head.sign;
            res_exp   = {1'b0, head.exp} - (EXP_W+1)'(BIAS);
            res_mant  = {(head.exp != '0), head.frac};
            res_flags = head.status;
        end
    end

endmodule

// File: tb/tb_fpu_result_reader.sv
// Directed bench for fpu_result_reader: stimulus queues hand-computed expected
// head values, a negedge monitor pops and compares on every handshake.
module tb_fpu_result_reader;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    typedef logic [37:0] ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_stat;
    logic        res_valid;
    logic        res_ready;
    logic        res_sign;
    logic [6:0]  res_exp;
    logic [25:0] res_mant;
    logic [3:0]  res_flags;
    logic [2:0]  fifo_count;
    logic [7:0]  ovf_cnt;
    logic [7:0]  unf_cnt;
    logic [7:0]  inx_cnt;
    logic [7:0]  drop_cnt;

    int   checks  = 0;
    int   errors  = 0;
    int   pop_cnt = 0;
    ent_t sb[$];

    fpu_result_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock100KHz   (clk),
        .reset         (reset),
        .fpu_data_in   (fpu_data),
        .fpu_status_in (fpu_stat),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_sign      (res_sign),
        .res_exp       (res_exp),
        .res_mant      (res_mant),
        .res_flags     (res_flags),
        .fifo_count    (fifo_count),
        .ovf_cnt       (ovf_cnt),
        .unf_cnt       (unf_cnt),
        .inx_cnt       (inx_cnt),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic ent_t ent(input logic s, input logic [6:0] e,
                                 input logic [25:0] m, input logic [3:0] f);
        return {s, e, m, f};
    endfunction

    // Present one FPU output for one clock; returns just after the sampling edge.
    task automatic drive(input logic [31:0] d, input logic [3:0] s);
        fpu_data = d;
        fpu_stat = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(32'h0, 4'b0000);
    endtask

    task automatic drain(input string name);
        res_ready = 1'b1;
        for (int k = 0; k < 64 && fifo_count != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_count"}, 64'(fifo_count), 64'(0));
        check({name, "_sb"}, 64'(sb.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                ent_t e;
                e = sb.pop_front();
                check("head", 64'({res_sign, res_exp, res_mant, res_flags}), 64'(e));
            end
            pop_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        fpu_data  = '0;
        fpu_stat  = '0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_count", 64'(fifo_count), 64'(0));
        check("rst_cnts",  64'({ovf_cnt, unf_cnt, inx_cnt, drop_cnt}), 64'(0));
        check("rst_fields", 64'({res_sign, res_exp, res_mant, res_flags}), 64'(0));
        reset = 1'b1;
        idle(2);

        // Held exact result: exp field 10 -> -21 (7'h6B), frac 0x1000000, hidden 1.
        sb.push_back(ent(1'b0, 7'h6B, 26'h3000000, 4'b0001));
        drive(32'h1500_0000, 4'b0001);
        check("lat_edge1_valid", 64'(res_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_edge2_valid", 64'(res_valid), 64'(1));
        for (int k = 0; k < 18; k++) drive(32'h1500_0000, 4'b0001);
        idle(5);
        check("held_once", 64'(pop_cnt), 64'(1));

        // Back-to-back inexact results without a 0000 gap.
        sb.push_back(ent(1'b0, 7'h6B, 26'h3000000, 4'b1000));
        sb.push_back(ent(1'b0, 7'h6B, 26'h3200000, 4'b1000));
        drive(32'h1500_0000, 4'b1000);
        drive(32'h1520_0000, 4'b1000);
        idle(4);
        check("b2b_pops", 64'(pop_cnt), 64'(3));
        check("inx_cnt", 64'(inx_cnt), 64'(2));

        // Overflow burst into a stalled FIFO: exp field 16 -> -15 (7'h71).
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i < DEPTH) sb.push_back(ent(1'b0, 7'h71, 26'h2000000 + 26'(i), 4'b0010));
            drive(32'h2000_0000 + 32'(i), 4'b0010);
        end
        idle(3);
        check("full_count", 64'(fifo_count), 64'(DEPTH));
        check("drop_cnt", 64'(drop_cnt), 64'(2));
        check("ovf_cnt", 64'(ovf_cnt), 64'(DEPTH + 2));
        drain("drain_ovf");

        // Full FIFO with a pop and a capture on the same edge: exp field 32 -> +1.
        res_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back(ent(1'b0, 7'h01, 26'h2000000 + 26'(i), 4'b0001));
            drive(32'h4000_0000 + 32'(i), 4'b0001);
        end
        idle(3);
        check("refill_count", 64'(fifo_count), 64'(DEPTH));
        sb.push_back(ent(1'b0, 7'h01, 26'h2000009, 4'b0001));
        drive(32'h4000_0009, 4'b0001);
        fpu_stat  = 4'b0000;
        fpu_data  = 32'h0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("pushpop_count", 64'(fifo_count), 64'(DEPTH));
        check("pushpop_drop", 64'(drop_cnt), 64'(2));
        drain("drain_pushpop");

        // 300 underflow events, sign set, exp field 0 -> -31 (7'h61), hidden 0.
        res_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sb.push_back(ent(1'b1, 7'h61, 26'(i), 4'b0100));
            drive(32'h8000_0000 | 32'(i), 4'b0100);
            idle(1);
        end
        idle(3);
        check("unf_sat", 64'(unf_cnt), 64'(255));
        check("unf_drop", 64'(drop_cnt), 64'(2));
        drain("drain_unf");

        // Denormal head inspected directly while stalled.
        res_ready = 1'b0;
        sb.push_back(ent(1'b0, 7'h61, 26'h0000001, 4'b0100));
        drive(32'h0000_0001, 4'b0100);
        idle(2);
        check("denorm_exp", 64'(res_exp), 64'(7'h61));
        check("denorm_mant", 64'(res_mant), 64'(26'h0000001));
        check("denorm_unf_held", 64'(unf_cnt), 64'(255));
        drain("drain_denorm");

        // Asynchronous reset with three entries queued.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(32'h4000_0010 + 32'(i), 4'b1010);
        idle(2);
        check("pre_rst_count", 64'(fifo_count), 64'(3));
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", 64'(res_valid), 64'(0));
        check("async_count", 64'(fifo_count), 64'(0));
        check("async_cnts", 64'({ovf_cnt, unf_cnt, inx_cnt, drop_cnt}), 64'(0));
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Operation resumes after release.
        res_ready = 1'b1;
        sb.push_back(ent(1'b1, 7'h01, 26'h2000005, 4'b0010));
        drive(32'hC000_0005, 4'b0010);
        idle(4);
        check("resume_ovf", 64'(ovf_cnt), 64'(1));
        drain("drain_resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
